// File: rtl/load_store_unit.sv
// load_store_unit: initiator side of the core's data-memory port.
// Takes one RV32I load/store at a time (byte address + funct3), drives a
// word-addressed memory with byte enables, splits accesses that cross a word
// boundary into two transactions and returns extended load data.
//
// Ports:
//   clk, rst                      clock, async active-high reset
//   req_valid/req_ready           request handshake (ready only when idle)
//   req_write, req_funct3         1=store; RV32I size/sign encoding
//   req_addr, req_wdata           byte address, right-justified store data
//   resp_valid/resp_rdata/resp_err  one-cycle completion, load data, illegal op
//   mem_req/mem_we/mem_addr/mem_be/mem_wdata  registered memory request
//   mem_gnt                       request accepted this cycle
//   mem_rvalid/mem_rdata          read data return
module load_store_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [29:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 30;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE0 = 3'd1,
    WAIT0  = 3'd2,
    ISSUE1 = 3'd3,
    WAIT1  = 3'd4,
    RESP   = 3'd5
  } state_t;

  state_t state, state_nx;

  // Latched request
  logic          l_write;
  logic [2:0]    l_f3;
  logic [DW-1:0] l_addr;
  logic [DW-1:0] l_wdata;

  // Captured read words
  logic [DW-1:0] lo, hi, lo_nx, hi_nx;

  // Next values of registered outputs
  logic          req_ready_nx, resp_valid_nx, resp_err_nx;
  logic [DW-1:0] resp_rdata_nx;
  logic          mem_req_nx, mem_we_nx;
  logic [AW-1:0] mem_addr_nx;
  logic [3:0]    mem_be_nx;
  logic [DW-1:0] mem_wdata_nx;

  // Request fields: live inputs while idle (accept cycle), latched copy after
  logic          src_write;
  logic [2:0]    src_f3;
  logic [DW-1:0] src_addr;
  logic [DW-1:0] src_wdata;

  assign src_write = (state == IDLE) ? req_write  : l_write;
  assign src_f3    = (state == IDLE) ? req_funct3 : l_f3;
  assign src_addr  = (state == IDLE) ? req_addr   : l_addr;
  assign src_wdata = (state == IDLE) ? req_wdata  : l_wdata;

  // Access decode: legality, size, lane masks, split detection
  logic          legal;
  logic [1:0]    off;
  logic [2:0]    size;
  logic [7:0]    be_base, be8;
  logic [63:0]   wd64;
  logic          split;
  logic [AW-1:0] word0, word1;

  always_comb begin
    case (src_f3)
      3'b000, 3'b001, 3'b010: legal = 1'b1;
      3'b100, 3'b101:         legal = ~src_write;
      default:                legal = 1'b0;
    endcase
  end

  always_comb begin
    case (src_f3[1:0])
      2'b00:   begin size = 3'd1; be_base = 8'h01; end
      2'b01:   begin size = 3'd2; be_base = 8'h03; end
      default: begin size = 3'd4; be_base = 8'h0F; end
    endcase
  end

  assign off   = src_addr[1:0];
  assign be8   = be_base << off;
  assign wd64  = 64'(src_wdata) << {off, 3'b000};
  assign split = (3'(off) + size) > 3'd4;
  assign word0 = src_addr[31:2];
  assign word1 = word0 + AW'(1);   // wraps at the top of the address space

  // Load result: align the two-word window, then extend to 32 bits
  logic [DW-1:0] r32, load_val;

  always_comb begin
    r32 = 32'({hi_nx, lo_nx} >> {off, 3'b000});
    case (src_f3)
      3'b000:  load_val = {{24{r32[7]}},  r32[7:0]};
      3'b001:  load_val = {{16{r32[15]}}, r32[15:0]};
      3'b010:  load_val = r32;
      3'b100:  load_val = {24'b0, r32[7:0]};
      3'b101:  load_val = {16'b0, r32[15:0]};
      default: load_val = '0;
    endcase
  end

  // Next-state and next-output logic
  always_comb begin
    state_nx     = state;
    lo_nx        = lo;
    hi_nx        = hi;
    mem_we_nx    = mem_we;
    mem_addr_nx  = mem_addr;
    mem_be_nx    = mem_be;
    mem_wdata_nx = mem_wdata;

    case (state)
      IDLE:   if (req_valid) state_nx = legal ? ISSUE0 : RESP;
      ISSUE0: if (mem_gnt) begin
                if (!src_write)  state_nx = WAIT0;
                else if (split)  state_nx = ISSUE1;
                else             state_nx = RESP;
              end
      WAIT0:  if (mem_rvalid) begin
                lo_nx    = mem_rdata;
                state_nx = split ? ISSUE1 : RESP;
              end
      ISSUE1: if (mem_gnt) state_nx = src_write ? RESP : WAIT1;
      WAIT1:  if (mem_rvalid) begin
                hi_nx    = mem_rdata;
                state_nx = RESP;
              end
      RESP:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase

    // Memory fields are loaded when entering an issue state and then held
    if (state_nx == ISSUE0) begin
      mem_we_nx    = src_write;
      mem_addr_nx  = word0;
      mem_be_nx    = be8[3:0];
      mem_wdata_nx = wd64[31:0];
    end else if (state_nx == ISSUE1) begin
      mem_we_nx    = src_write;
      mem_addr_nx  = word1;
      mem_be_nx    = be8[7:4];
      mem_wdata_nx = wd64[63:32];
    end

    req_ready_nx  = (state_nx == IDLE);
    mem_req_nx    = (state_nx == ISSUE0) || (state_nx == ISSUE1);
    resp_valid_nx = (state_nx == RESP);
    resp_err_nx   = resp_valid_nx && !legal;
    resp_rdata_nx = (resp_valid_nx && legal && !src_write) ? load_val : '0;
  end

  // State, datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      l_write    <= 1'b0;
      l_f3       <= '0;
      l_addr     <= '0;
      l_wdata    <= '0;
      lo         <= '0;
      hi         <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_be     <= '0;
      mem_wdata  <= '0;
    end else begin
      state      <= state_nx;
      lo         <= lo_nx;
      hi         <= hi_nx;
      req_ready  <= req_ready_nx;
      resp_valid <= resp_valid_nx;
      resp_rdata <= resp_rdata_nx;
      resp_err   <= resp_err_nx;
      mem_req    <= mem_req_nx;
      mem_we     <= mem_we_nx;
      mem_addr   <= mem_addr_nx;
      mem_be     <= mem_be_nx;
      mem_wdata  <= mem_wdata_nx;
      if (state == IDLE && req_valid) begin
        l_write <= req_write;
        l_f3    <= req_funct3;
        l_addr  <= req_addr;
        l_wdata <= req_wdata;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: self-checking bench for load_store_unit.
// A byte-level reference model predicts the memory transactions, load
// results and latency of every request; a memory responder with optional
// grant/read stalls and spurious idle rvalids checks each issued transaction.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid, req_ready, req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [29:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
  );

  typedef struct packed {
    logic        we;
    logic [29:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } txn_t;

  txn_t        expq[$];
  logic [31:0] mem [logic [29:0]];
  int          errors = 0;
  int          checks = 0;
  int          stalls, cfg_gstall, cfg_rdly, gnt_left;
  bit          rd_pend = 1'b0;
  int          rd_dly;
  logic [31:0] rd_data;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mrd(input logic [29:0] a);
    if (mem.exists(a)) return mem[a];
    return (32'(a) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    logic [31:0] m = '0;
    for (int i = 0; i < 4; i++) if (be[i]) m[8*i +: 8] = 8'hFF;
    return m;
  endfunction

  // Reference model: walk the accessed bytes one by one, group them by word
  task automatic model(input bit write, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, output bit legal,
                       output logic [31:0] val, output int base);
    txn_t        tx[2];
    int          ntx = 0;
    int          nb;
    logic [31:0] a, w32;
    logic [29:0] w;
    logic [7:0]  b;
    int          l;
    legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2) || (!write && (f3 == 3'd4 || f3 == 3'd5));
    val = '0;
    base = 1;
    if (!legal) return;
    nb = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    for (int k = 0; k < nb; k++) begin
      a = addr + 32'(k);
      w = a[31:2];
      l = int'(a[1:0]);
      w32 = mrd(w);
      b = write ? wdata[8*k +: 8] : w32[8*l +: 8];
      if (ntx == 0 || tx[ntx-1].addr != w) begin
        tx[ntx] = '{we: write, addr: w, be: 4'b0, wdata: 32'b0};
        ntx++;
      end
      tx[ntx-1].be[l] = 1'b1;
      if (write) tx[ntx-1].wdata[8*l +: 8] = b;
      else       val[8*k +: 8] = b;
    end
    if (!write && !f3[2]) begin
      if (nb == 1)      val = {{24{val[7]}}, val[7:0]};
      else if (nb == 2) val = {{16{val[15]}}, val[15:0]};
    end
    for (int i = 0; i < ntx; i++) expq.push_back(tx[i]);
    base = write ? 1 + ntx : 1 + 2 * ntx;
  endtask

  // Memory responder: checks each issued request against the expected queue
  initial begin
    txn_t        t;
    logic [31:0] w;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
      if (!rst) begin
        if (rd_pend) begin
          if (rd_dly == 0) begin mem_rvalid = 1'b1; mem_rdata = rd_data; rd_pend = 1'b0; end
          else begin rd_dly--; stalls++; end
        end else if (req_ready && $urandom_range(0, 3) == 0) begin
          mem_rvalid = 1'b1;   // spurious return while idle
        end
        if (mem_req) begin
          if (expq.size() == 0) begin
            chk("mem_unexpected", 64'(mem_req), 64'(0));
            mem_gnt = 1'b1;
            if (!mem_we) begin rd_pend = 1'b1; rd_dly = 0; rd_data = '0; end
          end else begin
            t = expq[0];
            chk("mem_we", 64'(mem_we), 64'(t.we));
            chk("mem_addr", 64'(mem_addr), 64'(t.addr));
            chk("mem_be", 64'(mem_be), 64'(t.be));
            if (t.we) chk("mem_wdata", 64'(mem_wdata & lane_mask(t.be)), 64'(t.wdata));
            if (gnt_left > 0) begin
              gnt_left--; stalls++;
            end else begin
              mem_gnt = 1'b1;
              void'(expq.pop_front());
              gnt_left = cfg_gstall;
              if (mem_we) begin
                w = mrd(mem_addr);
                for (int i = 0; i < 4; i++) if (mem_be[i]) w[8*i +: 8] = mem_wdata[8*i +: 8];
                mem[mem_addr] = w;
              end else begin
                rd_pend = 1'b1; rd_dly = cfg_rdly; rd_data = mrd(mem_addr);
              end
            end
          end
        end
      end
    end
  end

  // One request from an idle cycle to the cycle after its response
  task automatic do_op(input bit write, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input int gst, input int rdl, input string tag);
    bit          legal, got;
    logic [31:0] exp;
    int          base, n;
    chk({tag, ".ready"}, 64'(req_ready), 64'(1));
    model(write, f3, addr, wdata, legal, exp, base);
    cfg_gstall = gst; gnt_left = gst; cfg_rdly = rdl; stalls = 0;
    req_valid = 1'b1; req_write = write; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    n = 0; got = 1'b0;
    while (!got && n < 80) begin
      @(posedge clk); #1;
      if (n == 0) begin
        req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
        req_funct3 = 3'($urandom_range(0, 7)); req_write = 1'($urandom_range(0, 1));
      end
      n++;
      if (resp_valid) got = 1'b1;
    end
    chk({tag, ".resp_seen"}, 64'(got), 64'(1));
    if (got) begin
      chk({tag, ".latency"}, 64'(n), 64'(base + stalls));
      chk({tag, ".rdata"}, 64'(resp_rdata), 64'(exp));
      chk({tag, ".err"}, 64'(resp_err), 64'(!legal));
      @(posedge clk); #1;
      chk({tag, ".pulse"}, 64'(resp_valid), 64'(0));
      chk({tag, ".txn_left"}, 64'(expq.size()), 64'(0));
    end else begin
      rst = 1'b1; #1; expq.delete(); rd_pend = 1'b0;
      @(posedge clk); #1; rst = 1'b0;
    end
  endtask

  // Reset asserted ncyc cycles after acceptance of a word load
  task automatic rst_mid(input int ncyc, input int gst, input int rdl, input string tag);
    bit          legal;
    logic [31:0] exp;
    int          base;
    model(1'b0, 3'd2, 32'h200, 32'h0, legal, exp, base);
    cfg_gstall = gst; gnt_left = gst; cfg_rdly = rdl; stalls = 0;
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'd2; req_addr = 32'h200;
    @(posedge clk); #1; req_valid = 1'b0;
    for (int i = 1; i < ncyc; i++) begin @(posedge clk); #1; end
    chk({tag, ".busy"}, 64'(req_ready), 64'(0));
    rst = 1'b1; #1;
    chk({tag, ".mem_req"}, 64'(mem_req), 64'(0));
    chk({tag, ".ready"}, 64'(req_ready), 64'(1));
    expq.delete();
    @(posedge clk); #1; rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk({tag, ".no_resp"}, 64'(resp_valid), 64'(0));
    end
    chk({tag, ".rvalid_drained"}, 64'(rd_pend), 64'(0));
  endtask

  initial begin
    bit          wr;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [2:0]  lf3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    req_valid = 1'b0; req_write = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
    cfg_gstall = 0; cfg_rdly = 0; gnt_left = 0; stalls = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.req_ready", 64'(req_ready), 64'(1));
    chk("rst.resp_valid", 64'(resp_valid), 64'(0));
    chk("rst.resp_rdata", 64'(resp_rdata), 64'(0));
    chk("rst.resp_err", 64'(resp_err), 64'(0));
    chk("rst.mem_req", 64'(mem_req), 64'(0));
    chk("rst.mem_we", 64'(mem_we), 64'(0));
    chk("rst.mem_addr", 64'(mem_addr), 64'(0));
    chk("rst.mem_be", 64'(mem_be), 64'(0));
    chk("rst.mem_wdata", 64'(mem_wdata), 64'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    mem[30'h40] = 32'h8000_00F0;
    do_op(1'b0, 3'd2, 32'h100, 32'h0, 0, 0, "lw_aligned");
    mem[30'h40] = 32'h80AB_CDEF;
    do_op(1'b0, 3'd0, 32'h103, 32'h0, 0, 0, "lb_103");
    do_op(1'b0, 3'd4, 32'h103, 32'h0, 0, 0, "lbu_103");
    do_op(1'b1, 3'd1, 32'h7, 32'h0000_BEEF, 0, 0, "sh_split");
    do_op(1'b0, 3'd5, 32'h7, 32'h0, 0, 0, "lhu_split");
    mem[30'h3FFF_FFFF] = 32'hAABB_1122;
    mem[30'h0] = 32'h3344_CCDD;
    do_op(1'b0, 3'd2, 32'hFFFF_FFFE, 32'h0, 0, 0, "lw_wrap");
    do_op(1'b0, 3'd2, 32'hFFFF_FFFE, 32'h0, 3, 2, "lw_wrap_stall");
    do_op(1'b1, 3'd2, 32'h5, 32'h1122_3344, 3, 2, "sw_split_stall");
    do_op(1'b0, 3'd1, 32'h6, 32'h0, 2, 3, "lh_stall");
    do_op(1'b1, 3'd4, 32'h10, 32'hFFFF_FFFF, 0, 0, "st_f3_100");
    do_op(1'b0, 3'd3, 32'h10, 32'h0, 0, 0, "ld_f3_011");
    do_op(1'b1, 3'd7, 32'h10, 32'h0, 0, 0, "st_f3_111");
    rst_mid(1, 10, 0, "rst_issue0");
    rst_mid(2, 0, 4, "rst_wait0");

    for (int i = 0; i < 200; i++) begin
      wr = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) f3 = 3'($urandom_range(0, 7));
      else if (wr)                   f3 = 3'($urandom_range(0, 2));
      else                           f3 = lf3[$urandom_range(0, 4)];
      a = $urandom_range(0, 1) ? 32'hFFFF_FFC0 + 32'($urandom_range(0, 63))
                               : 32'($urandom_range(0, 63));
      do_op(wr, f3, a, $urandom,
            ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
            ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
